// File: rtl/demux_stream.sv
// demux_stream -- registered 1-to-CHANNELS stream demultiplexer.
//
// One producer feeds CHANNELS consumers through a one-word holding register
// per channel. A word goes to channel in_sel, or to every channel when
// in_bcast is set (all-or-nothing: a broadcast waits until every channel
// can take it). Each channel refills on the same edge it drains, so a
// consumer holding out_ready=1 sees one word per cycle.
//
// Optional feature macro: DEMUX_BADSEL_EN
//   defined   : err port present; a unicast word with in_sel >= CHANNELS is
//               accepted, dropped, and sets the sticky err flag until rst.
//   undefined : no err port; an out-of-range in_sel holds in_ready low.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   producer has a word
//   in_ready   word is accepted this cycle (independent of in_valid)
//   in_data    input word (WIDTH)
//   in_sel     target channel index (SEL_W)
//   in_bcast   write the word to every channel, in_sel ignored
//   out_valid  per-channel holding register is full (CHANNELS)
//   out_ready  per-channel consumer takes the word (CHANNELS)
//   out_data   channel k at bits [k*WIDTH +: WIDTH]
//   err        sticky bad-select flag (DEMUX_BADSEL_EN only)

// Per-channel holding register.
module demux_stream_chan #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             can_take
);
  // Free now, or being emptied on this same edge.
  assign can_take = !full || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      // Load wins over a simultaneous drain: the new word replaces the old.
      full <= 1'b1;
      data <= din;
    end else if (ready) begin
      // Data is kept after a drain; only the full flag drops.
      full <= 1'b0;
    end
  end
endmodule

module demux_stream #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [$clog2(CHANNELS)-1:0] in_sel,
  input  logic                        in_bcast,
  output logic [CHANNELS-1:0]         out_valid,
  input  logic [CHANNELS-1:0]         out_ready,
  output logic [CHANNELS*WIDTH-1:0]   out_data
`ifdef DEMUX_BADSEL_EN
  ,
  output logic                        err
`endif
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int PAD   = 1 << SEL_W;

  logic [CHANNELS-1:0]            can_take;
  logic [PAD-1:0]                 can_take_pad;
  logic [CHANNELS-1:0]            load;
  logic [CHANNELS-1:0][WIDTH-1:0] ch_data;
  logic                           sel_ok;
  logic                           accept;

  // Only a non-power-of-two channel count can see an out-of-range select.
  generate
    if (PAD == CHANNELS) begin : g_pow2
      assign sel_ok = 1'b1;
    end else begin : g_npow2
      assign sel_ok = (in_sel < SEL_W'(CHANNELS));
    end
  endgenerate

  // Zero-padded so in_sel can index it over its full range.
  assign can_take_pad = PAD'(can_take);

  always_comb begin
    in_ready = 1'b0;
    if (in_bcast)
      in_ready = &can_take;
    else if (sel_ok)
      in_ready = can_take_pad[in_sel];
    else begin
`ifdef DEMUX_BADSEL_EN
      in_ready = 1'b1;   // swallow the word, flag it below
`else
      in_ready = 1'b0;   // stall until the producer fixes in_sel
`endif
    end
  end

  assign accept = in_valid && in_ready;

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_ch
      assign load[k] = accept && (in_bcast || (sel_ok && (in_sel == SEL_W'(k))));

      demux_stream_chan #(.WIDTH(WIDTH)) u_chan (
        .clk      (clk),
        .rst      (rst),
        .load     (load[k]),
        .din      (in_data),
        .ready    (out_ready[k]),
        .full     (out_valid[k]),
        .data     (ch_data[k]),
        .can_take (can_take[k])
      );
    end
  endgenerate

  assign out_data = ch_data;

`ifdef DEMUX_BADSEL_EN
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (accept && !in_bcast && !sel_ok)
      err <= 1'b1;
  end
`endif
endmodule
